// File: rtl/uart_pkg.sv
// Shared UART constants and the increment calculator used to pick a baud
// generator's reset increment from clock and baud figures.
package uart_pkg;

   localparam int DEFAULT_OVERSAMPLE = 16;

   // round(baud * oversample * 2^acc_width / clk_freq), all in 64-bit integers
   function automatic longint unsigned baud_inc(
      input longint unsigned clk_freq,
      input longint unsigned baud,
      input longint unsigned oversample,
      input longint unsigned acc_width
   );
      longint unsigned num;
      num = baud * oversample * (64'd1 << acc_width);
      return (num + clk_freq / 64'd2) / clk_freq;
   endfunction

endpackage

// File: rtl/uart_phase_accumulator.sv
// ACC_WIDTH-bit phase accumulator; carry is the raw overflow of acc + inc and
// is meaningful to the caller only in cycles where it asserts advance.
module uart_phase_accumulator
   import uart_pkg::*;
#(
   parameter int ACC_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 advance,
   input  logic                 clear,
   input  logic [ACC_WIDTH-1:0] inc,
   output logic                 carry
);

   logic [ACC_WIDTH-1:0] acc_q;
   logic [ACC_WIDTH-1:0] acc_d;
   logic [ACC_WIDTH-1:0] sum;

   assign {carry, sum} = {1'b0, acc_q} + {1'b0, inc};

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (advance) begin
         acc_d = sum;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/uart_baud_generator.sv
// Fractional-N baud tick generator: phase-accumulator sample ticks, an
// oversample counter for bit / mid-bit ticks, and a shadowed increment.
module uart_baud_generator
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 150000000,
   parameter int DEFAULT_BAUD = 9600,
   parameter int OVERSAMPLE   = DEFAULT_OVERSAMPLE,
   parameter int ACC_WIDTH    = 16,
   parameter int DEFAULT_INC  = int'(baud_inc(64'(CLK_FREQ), 64'(DEFAULT_BAUD),
                                              64'(OVERSAMPLE), 64'(ACC_WIDTH))),
   localparam int IDX_W = $clog2(OVERSAMPLE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 restart,
   input  logic [ACC_WIDTH-1:0] inc_in,
   input  logic                 inc_load,
   output logic                 inc_pending,
   output logic                 sample_tick,
   output logic                 bit_tick,
   output logic                 mid_bit_tick,
   output logic [IDX_W-1:0]     sample_index
);

   localparam logic [ACC_WIDTH-1:0] RESET_INC = ACC_WIDTH'(DEFAULT_INC);
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0]     MID_IDX   = IDX_W'(OVERSAMPLE / 2 - 1);

   logic                 advance;
   logic                 carry_raw;
   logic                 carry;
   logic                 at_last;
   logic                 apply;
   logic [ACC_WIDTH-1:0] inc_q, inc_d;
   logic [ACC_WIDTH-1:0] pend_q, pend_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [IDX_W-1:0]     os_cnt_q, os_cnt_d;
   logic                 sample_q, sample_d;
   logic                 bit_tick_q, bit_tick_d;
   logic                 mid_tick_q, mid_tick_d;

   assign advance = enable && !restart;

   uart_phase_accumulator #(
      .ACC_WIDTH(ACC_WIDTH)
   ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .advance(advance),
      .clear  (restart),
      .inc    (inc_q),
      .carry  (carry_raw)
   );

   assign carry   = advance && carry_raw;
   assign at_last = carry && (os_cnt_q == LAST_IDX);
   // inc_load is a fire-and-forget strobe with no back-pressure: the value is
   // always accepted, inc_pending stays high until it replaces inc_q.
   // Swapping only at a bit boundary, while idle or on restart keeps every
   // bit period built from a single increment.
   assign apply   = pend_valid_q && (at_last || !enable || restart);

   always_comb begin
      sample_d     = carry;
      bit_tick_d   = at_last;
      mid_tick_d   = carry && (os_cnt_q == MID_IDX);
      os_cnt_d     = os_cnt_q;
      inc_d        = inc_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (restart) begin
         os_cnt_d = '0;
      end else if (carry) begin
         os_cnt_d = os_cnt_q + IDX_W'(1);
      end
      if (apply) begin
         inc_d        = pend_q;
         pend_valid_d = 1'b0;
      end
      if (inc_load) begin
         pend_d       = inc_in;
         pend_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         os_cnt_q     <= '0;
         inc_q        <= RESET_INC;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         sample_q     <= 1'b0;
         bit_tick_q   <= 1'b0;
         mid_tick_q   <= 1'b0;
      end else begin
         os_cnt_q     <= os_cnt_d;
         inc_q        <= inc_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         sample_q     <= sample_d;
         bit_tick_q   <= bit_tick_d;
         mid_tick_q   <= mid_tick_d;
      end
   end

   assign inc_pending  = pend_valid_q;
   assign sample_tick  = sample_q;
   assign bit_tick     = bit_tick_q;
   assign mid_bit_tick = mid_tick_q;
   assign sample_index = os_cnt_q;

endmodule

// File: tb/tb_uart_baud_generator.sv
// Bench for uart_baud_generator: a 4-bit/4x instance for directed and random
// scenarios, plus a default-parameter instance for the long-run rate check.
module tb_uart_baud_generator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   initial forever #5 clk = ~clk;

   // small instance: ACC_WIDTH=4, OVERSAMPLE=4, reset increment 5
   logic       en = 1'b0, rs = 1'b0, ld = 1'b0;
   logic [3:0] inc_in = 4'd0;
   logic       s_pend, s_samp, s_bit, s_mid;
   logic [1:0] s_idx;

   uart_baud_generator #(
      .CLK_FREQ(1000), .DEFAULT_BAUD(10), .OVERSAMPLE(4), .ACC_WIDTH(4), .DEFAULT_INC(5)
   ) dut_s (
      .clk(clk), .reset(rst), .enable(en), .restart(rs), .inc_in(inc_in), .inc_load(ld),
      .inc_pending(s_pend), .sample_tick(s_samp), .bit_tick(s_bit),
      .mid_bit_tick(s_mid), .sample_index(s_idx)
   );

   // default instance
   logic        d_en = 1'b0;
   logic        d_rs = 1'b0, d_ld = 1'b0;
   logic [15:0] d_inc_in = 16'd0;
   logic        d_pend, d_samp, d_bit, d_mid;
   logic [3:0]  d_idx;

   uart_baud_generator dut_d (
      .clk(clk), .reset(rst), .enable(d_en), .restart(d_rs), .inc_in(d_inc_in),
      .inc_load(d_ld), .inc_pending(d_pend), .sample_tick(d_samp), .bit_tick(d_bit),
      .mid_bit_tick(d_mid), .sample_index(d_idx)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference model of the small instance, in terms of total phase and
   // number of overflows since the last realign
   int   m_phase, m_inc, m_pend, m_ncar;
   bit   m_pend_v;
   logic e_pend, e_samp, e_bit, e_mid;
   int   e_idx;

   task automatic model_reset();
      m_phase = 0; m_inc = 5; m_pend = 0; m_pend_v = 0; m_ncar = 0;
      e_pend = 0; e_samp = 0; e_bit = 0; e_mid = 0; e_idx = 0;
   endtask

   // drive one cycle and predict what the outputs show after that edge
   task automatic cyc(input logic en_v, input logic rs_v, input logic ld_v,
                      input logic [3:0] inc_v);
      int total;
      bit carry, apply;
      en = en_v; rs = rs_v; ld = ld_v; inc_in = inc_v;
      total  = m_phase + m_inc;
      carry  = en_v && !rs_v && (total >= 16);
      e_samp = carry;
      e_bit  = carry && ((m_ncar + 1) % 4 == 0);
      e_mid  = carry && ((m_ncar + 1) % 4 == 2);
      apply  = m_pend_v && (e_bit || !en_v || rs_v);
      if (rs_v) begin
         m_phase = 0; m_ncar = 0;
      end else if (en_v) begin
         m_phase = total % 16;
         if (carry) m_ncar++;
      end
      if (apply) m_inc = m_pend;
      if (ld_v) begin
         m_pend = int'(inc_v); m_pend_v = 1;
      end else if (apply) begin
         m_pend_v = 0;
      end
      e_pend = m_pend_v;
      e_idx  = m_ncar % 4;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_all();
      en = 0; rs = 0; ld = 0; inc_in = 0; d_en = 0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // load a value while idle, then realign so it takes effect from phase 0
   task automatic set_inc(input logic [3:0] v);
      cyc(1'b0, 1'b0, 1'b1, v);
      cyc(1'b0, 1'b1, 1'b0, 4'd0);
   endtask

   task automatic test_reset();
      int cnt;
      reset_all();
      n_cmp++;
      if ({s_pend, s_samp, s_bit, s_mid, s_idx} !== 6'b0 ||
          {d_pend, d_samp, d_bit, d_mid, d_idx} !== 8'b0) begin
         n_err++;
         $display("FAIL reset_release: small=%b default=%b required all zero",
                  {s_pend, s_samp, s_bit, s_mid, s_idx}, {d_pend, d_samp, d_bit, d_mid, d_idx});
      end
      repeat (6) cyc(1'b1, 1'b0, 1'b0, 4'd0);
      cyc(1'b1, 1'b0, 1'b1, 4'd9);
      #3;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({s_pend, s_samp, s_bit, s_mid, s_idx} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_async: got %b required 000000",
                  {s_pend, s_samp, s_bit, s_mid, s_idx});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 4'd0);
         if (s_samp === 1'b1) cnt++;
      end
      n_cmp++;
      if (cnt != 5) begin
         n_err++;
         $display("FAIL reset_default_inc: %0d ticks in 16 cycles, required 5", cnt);
      end
   endtask

   task automatic test_ticks();
      logic [2:0] exp_t;
      set_inc(4'd4);
      for (int k = 1; k <= 32; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 4'd0);
         exp_t = {k % 4 == 0, k % 16 == 0, k % 16 == 8};
         n_cmp++;
         if ({s_samp, s_bit, s_mid} !== exp_t) begin
            n_err++;
            $display("FAIL ticks_inc4 cycle %0d: samp/bit/mid=%b required %b",
                     k, {s_samp, s_bit, s_mid}, exp_t);
         end
         if (k % 4 == 0) begin
            n_cmp++;
            if (s_idx !== 2'((k / 4) % 4)) begin
               n_err++;
               $display("FAIL ticks_index cycle %0d: got %0d required %0d",
                        k, s_idx, (k / 4) % 4);
            end
         end
      end
   endtask

   task automatic test_fractional();
      int ticks[$];
      int prev, gap, win;
      set_inc(4'd3);
      for (int k = 1; k <= 48; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 4'd0);
         if (s_samp === 1'b1) ticks.push_back(k);
      end
      for (int w = 0; w < 3; w++) begin
         win = 0;
         foreach (ticks[i]) if (ticks[i] > 16 * w && ticks[i] <= 16 * (w + 1)) win++;
         n_cmp++;
         if (win != 3) begin
            n_err++;
            $display("FAIL frac_window %0d: %0d ticks required 3", w, win);
         end
      end
      prev = 0;
      foreach (ticks[i]) begin
         gap = ticks[i] - prev;
         prev = ticks[i];
         n_cmp++;
         if (gap != 5 && gap != 6) begin
            n_err++;
            $display("FAIL frac_gap at cycle %0d: gap %0d required 5 or 6", ticks[i], gap);
         end
      end
   endtask

   task automatic test_deferred();
      set_inc(4'd4);
      repeat (5) cyc(1'b1, 1'b0, 1'b0, 4'd0);
      for (int k = 6; k <= 16; k++) begin
         cyc(1'b1, 1'b0, (k == 6), 4'd8);
         n_cmp++;
         if (s_pend !== (k < 16)) begin
            n_err++;
            $display("FAIL deferred_pending cycle %0d: got %b required %b", k, s_pend, k < 16);
         end
      end
      n_cmp++;
      if (s_bit !== 1'b1) begin
         n_err++;
         $display("FAIL deferred_bit_tick: got %b required 1", s_bit);
      end
      for (int k = 17; k <= 24; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 4'd0);
         n_cmp++;
         if (s_samp !== (k % 2 == 0)) begin
            n_err++;
            $display("FAIL deferred_period2 cycle %0d: got %b required %b", k, s_samp, k % 2 == 0);
         end
      end
   endtask

   task automatic test_restart_enable();
      set_inc(4'd4);
      repeat (6) cyc(1'b1, 1'b0, 1'b0, 4'd0);
      cyc(1'b1, 1'b0, 1'b1, 4'd8);
      // the add would overflow this cycle; restart must suppress it
      cyc(1'b1, 1'b1, 1'b0, 4'd0);
      n_cmp++;
      if ({s_pend, s_samp, s_bit, s_mid, s_idx} !== 6'b0) begin
         n_err++;
         $display("FAIL restart_clear: got %b required 000000",
                  {s_pend, s_samp, s_bit, s_mid, s_idx});
      end
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if ({s_samp, s_idx} !== 3'b101) begin
         n_err++;
         $display("FAIL restart_new_inc: samp/idx=%b required 101", {s_samp, s_idx});
      end
      set_inc(4'd4);
      repeat (6) cyc(1'b1, 1'b0, 1'b0, 4'd0);
      for (int k = 0; k < 10; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 4'd0);
         n_cmp++;
         if ({s_samp, s_bit, s_mid, s_idx} !== 5'b00001) begin
            n_err++;
            $display("FAIL enable_hold cycle %0d: got %b required 00001",
                     k, {s_samp, s_bit, s_mid, s_idx});
         end
      end
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if ({s_samp, s_mid, s_idx} !== 4'b1110) begin
         n_err++;
         $display("FAIL enable_resume: samp/mid/idx=%b required 1110", {s_samp, s_mid, s_idx});
      end
   endtask

   task automatic test_random();
      logic [5:0] got, exp_v;
      for (int k = 0; k < 400; k++) begin
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)));
         got   = {s_pend, s_samp, s_bit, s_mid, s_idx};
         exp_v = {e_pend, e_samp, e_bit, e_mid, 2'(e_idx)};
         n_cmp++;
         if (got !== exp_v) begin
            n_err++;
            $display("FAIL random cycle %0d: pend/samp/bit/mid/idx=%b required %b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_defaults();
      int n_s, n_b, n_m, x_s, x_b, x_m;
      longint unsigned carries;
      reset_all();
      d_en = 1'b1;
      n_s = 0; n_b = 0; n_m = 0;
      for (int k = 0; k < 65536; k++) begin
         @(posedge clk);
         #1;
         if (d_samp === 1'b1) n_s++;
         if (d_bit === 1'b1) n_b++;
         if (d_mid === 1'b1) n_m++;
      end
      d_en = 1'b0;
      carries = (64'd65536 * 64'd67) >> 16;
      x_s = int'(carries); x_b = 0; x_m = 0;
      for (int j = 1; j <= x_s; j++) begin
         if (j % 16 == 0) x_b++;
         if (j % 16 == 8) x_m++;
      end
      n_cmp++;
      if (n_s != x_s) begin
         n_err++;
         $display("FAIL defaults_sample: %0d ticks required %0d", n_s, x_s);
      end
      n_cmp++;
      if (n_b != x_b) begin
         n_err++;
         $display("FAIL defaults_bit: %0d ticks required %0d", n_b, x_b);
      end
      n_cmp++;
      if (n_m != x_m) begin
         n_err++;
         $display("FAIL defaults_mid: %0d ticks required %0d", n_m, x_m);
      end
      n_cmp++;
      if (d_idx !== 4'(x_s % 16) || d_pend !== 1'b0) begin
         n_err++;
         $display("FAIL defaults_index: idx=%0d pend=%b required idx=%0d pend=0",
                  d_idx, d_pend, x_s % 16);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ticks();
      test_fractional();
      test_deferred();
      test_restart_enable();
      test_random();
      test_defaults();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
